serializer: RTL and testbench

Parallel-to-serial converter feeding the deserializer stage. Captures a DATA_W-bit word plus a bit-count on a single-cycle request and emits the selected bits MSB first, one bit per clock, with a per-bit valid strobe. The output pair (ser_data_o, ser_data_val_o) connects directly to the deserializer's data_i / data_val_i. busy_o provides backpressure to the word source.

---
 rtl/serializer.sv | 121 ++++++++++++
 tb/tb_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends the top L bits of a captured word MSB first with a valid strobe.
// Optional SERIALIZER_BACK_TO_BACK_EN lets a new word be accepted in the cycle carrying the last bit.
module serializer #(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);
  localparam logic [MOD_W:0] CNT_FULL = (MOD_W+1)'(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [MOD_W:0]    cnt_q,   cnt_d;
  logic              accept_s;
  logic              busy_s;
  logic              ser_bit_s;
  logic              ser_val_s;
  logic [MOD_W:0]    load_len_s;

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      shift_q <= {DATA_W{1'b0}};
      cnt_q   <= {(MOD_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    accept_s   = data_val_i && !busy_s;
    // A zero bit count stands for a full word, so zero is never loaded
    load_len_s = (data_mod_i == {MOD_W{1'b0}}) ? CNT_FULL : {1'b0, data_mod_i};
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT;
          shift_d = data_i;
          cnt_d   = load_len_s;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          if (accept_s) begin
            state_d = SHIFT;
            shift_d = data_i;
            cnt_d   = load_len_s;
          end else begin
            state_d = IDLE;
            shift_d = {DATA_W{1'b0}};
            cnt_d   = {(MOD_W+1){1'b0}};
          end
        end else begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = {DATA_W{1'b0}};
        cnt_d   = {(MOD_W+1){1'b0}};
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    ser_val_s = 1'b0;
    ser_bit_s = 1'b0;
    busy_s    = 1'b0;
    case (state_q)
      IDLE: begin
        ser_val_s = 1'b0;
        ser_bit_s = 1'b0;
        busy_s    = 1'b0;
      end
      SHIFT: begin
        ser_val_s = 1'b1;
        ser_bit_s = shift_q[DATA_W-1];
`ifdef SERIALIZER_BACK_TO_BACK_EN
        busy_s    = (cnt_q != CNT_ONE);
`else
        busy_s    = 1'b1;
`endif
      end
      default: begin
        ser_val_s = 1'b0;
        ser_bit_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  assign ser_data_o     = ser_bit_s;
  assign ser_data_val_o = ser_val_s;
  assign busy_o         = busy_s;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a bit-queue reference model predicts the serial stream and busy_o.
module tb_serializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);
`ifdef SERIALIZER_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic              clk_i;
  logic              arst_n_i;
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  serializer #(.DATA_W(DATA_W)) dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errs   = 0;
  int checks = 0;

  // Reference: queue of bits still to appear on the serial line, one popped per clock
  bit        exp_q[$];
  bit [15:0] sent_q[$];
  bit        loop_en   = 1'b0;
  bit [15:0] rx_word   = 16'h0000;
  int        rx_bits   = 0;
  int        rx_words  = 0;
  bit        last_acc  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    if (exp_q.size() > 1) return 1'b1;
    if (exp_q.size() == 1) return !BTB;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, compare at the following negedge
  task automatic cycle(input bit v, input bit [15:0] d, input bit [3:0] m);
    bit acc;
    int len;
    data_val_i = v;
    data_i     = d;
    data_mod_i = m;
    acc = v && !model_busy();
    @(posedge clk_i);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      len = (m == 4'd0) ? 16 : int'(m);
      for (int i = 0; i < len; i++) exp_q.push_back(d[15-i]);
      if (loop_en) sent_q.push_back(d);
    end
    last_acc = acc;
    @(negedge clk_i);
    check("val",  {31'd0, ser_data_val_o}, {31'd0, exp_q.size() > 0});
    check("bit",  {31'd0, ser_data_o},     {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
    check("busy", {31'd0, busy_o},         {31'd0, model_busy()});
    if (loop_en && ser_data_val_o) begin
      rx_word = {rx_word[14:0], ser_data_o};
      rx_bits++;
      if (rx_bits == 16) begin
        rx_bits = 0;
        rx_words++;
        if (sent_q.size() > 0) check("loop_word", {16'd0, rx_word}, {16'd0, sent_q.pop_front()});
        else check("loop_extra", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 4'd0);
  endtask

  initial begin
    int gap_cnt;
    int guard;
    arst_n_i   = 1'b0;
    data_i     = 16'h0000;
    data_mod_i = 4'd0;
    data_val_i = 1'b0;
    #3;
    check("rst_val",  {31'd0, ser_data_val_o}, 32'd0);
    check("rst_bit",  {31'd0, ser_data_o},     32'd0);
    check("rst_busy", {31'd0, busy_o},         32'd0);
    #9 arst_n_i = 1'b1;
    @(negedge clk_i);
    idle(2);

    // Full word, then partial words
    cycle(1'b1, 16'hA5C3, 4'd0);
    idle(17);
    cycle(1'b1, 16'hF0FF, 4'd3);
    idle(4);
    cycle(1'b1, 16'h7FFF, 4'd1);
    idle(2);

    // Dropped request while busy
    cycle(1'b1, 16'h1234, 4'd0);
    idle(3);
    cycle(1'b1, 16'hFFFF, 4'd0);
    idle(14);

    // Back-to-back with data_val_i held high
    cycle(1'b1, 16'hA000, 4'd4);
    gap_cnt = 0;
    guard   = 0;
    do begin
      cycle(1'b1, 16'h6000, 4'd4);
      guard++;
    end while (!last_acc && guard < 10);
    check("b2b_accept", {31'd0, last_acc}, 32'd1);
    idle(6);

    // Reset mid-word after 5 of 16 bits
    cycle(1'b1, 16'hBEEF, 4'd0);
    idle(4);
    #2 arst_n_i = 1'b0;
    #1;
    check("mid_rst_val",  {31'd0, ser_data_val_o}, 32'd0);
    check("mid_rst_bit",  {31'd0, ser_data_o},     32'd0);
    check("mid_rst_busy", {31'd0, busy_o},         32'd0);
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    #2 arst_n_i = 1'b1;
    idle(4);

    // Randomized requests, lengths and timing
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
    idle(18);

    // Loopback: 100 full random words reassembled and compared
    loop_en = 1'b1;
    rx_bits = 0;
    guard   = 0;
    while (sent_q.size() + rx_words < 100 && guard < 5000) begin
      cycle(!model_busy(), 16'($urandom), 4'd0);
      guard++;
    end
    guard = 0;
    while (rx_words < 100 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("loop_count", rx_words, 32'd100);
    loop_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
